// File: rtl/stack_btn_ctrl.sv
// stack_btn_ctrl: button/switch front end for the 8x4 lab stack.
// Synchronizes the raw buttons and switches, debounces each button,
// turns accepted presses into one-cycle push/pop strobes and registers the
// data that accompanies a push.
// Optional build macro STACK_BTN_ERR_EN: when defined, an illegal request
// (push into a full stack or pop from an empty one) holds err high for
// ERR_HOLD_CYCLES cycles. When undefined, err is tied low and full/empty
// are ignored.

// Per-button debouncer: the level must differ from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles before it is taken.
module stack_btn_dbnc #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rstN,
  input  logic s,
  output logic stable
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Any cycle matching the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (s == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= s;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module stack_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ERR_HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       btn_push,
  input  logic       btn_pop,
  input  logic [3:0] sw_data,
  input  logic       full,
  input  logic       empty,
  output logic       push,
  output logic       pop,
  output logic [3:0] data_in,
  output logic       err
);
  localparam int NUM_BTN = 2;  // bit 0 = push button, bit 1 = pop button

  logic               sync_push, sync_pop, s_push, s_pop;
  logic [3:0]         sync_data, s_data;
  logic [NUM_BTN-1:0] s_btn, stable, stable_d, rise;

  // Two-flop synchronizers for every asynchronous input.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_push <= 1'b0;
      sync_pop  <= 1'b0;
      sync_data <= '0;
      s_push    <= 1'b0;
      s_pop     <= 1'b0;
      s_data    <= '0;
    end else begin
      sync_push <= btn_push;
      sync_pop  <= btn_pop;
      sync_data <= sw_data;
      s_push    <= sync_push;
      s_pop     <= sync_pop;
      s_data    <= sync_data;
    end
  end

  assign s_btn = {s_pop, s_push};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    stack_btn_dbnc #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc (
      .clk    (clk),
      .rstN   (rstN),
      .s      (s_btn[gi]),
      .stable (stable[gi])
    );
  end

  // Only the rising edge of an accepted level makes a strobe.
  assign rise = stable & ~stable_d;

  // Strobes and push data; data_in is captured on the edge that raises push
  // so it is already valid while the stack samples the strobe.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stable_d <= '0;
      push     <= 1'b0;
      pop      <= 1'b0;
      data_in  <= '0;
    end else begin
      stable_d <= stable;
      push     <= rise[0];
      pop      <= rise[1];
      if (rise[0]) data_in <= s_data;
    end
  end

`ifdef STACK_BTN_ERR_EN
  typedef enum logic {IDLE, HOLD} err_st_t;
  localparam int EC_W = $clog2(ERR_HOLD_CYCLES + 1);
  localparam logic [EC_W-1:0] EC_LOAD = EC_W'(ERR_HOLD_CYCLES);
  localparam logic [EC_W-1:0] EC_ONE  = EC_W'(1);

  err_st_t         st, st_nxt;
  logic [EC_W-1:0] ecnt, ecnt_nxt;
  logic            illegal;

  // Flags are looked at during the strobe cycle, before the stack acts on it.
  assign illegal = (push & ~pop & full) | (pop & ~push & empty);

  // Error state and hold counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      st   <= IDLE;
      ecnt <= '0;
    end else begin
      st   <= st_nxt;
      ecnt <= ecnt_nxt;
    end
  end

  // Load on an illegal request (also retriggers in HOLD), count down to 1.
  always_comb begin
    st_nxt   = st;
    ecnt_nxt = ecnt;
    if (illegal) begin
      st_nxt   = HOLD;
      ecnt_nxt = EC_LOAD;
    end else if (st == HOLD) begin
      if (ecnt == EC_ONE) begin
        st_nxt   = IDLE;
        ecnt_nxt = '0;
      end else begin
        ecnt_nxt = ecnt - 1'b1;
      end
    end
  end

  assign err = (st == HOLD);
`else
  logic [33:0] unused_err_cfg;

  assign err = 1'b0;
  assign unused_err_cfg = {full, empty, 32'(ERR_HOLD_CYCLES)};
`endif
endmodule

// File: tb/tb_stack_btn_ctrl.sv
// Directed bench for stack_btn_ctrl with DEBOUNCE_CYCLES=4, ERR_HOLD_CYCLES=8.
// err expectations follow whether STACK_BTN_ERR_EN is defined for the build.
module tb_stack_btn_ctrl;
`ifdef STACK_BTN_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstN;
  logic       btn_push, btn_pop, full, empty;
  logic [3:0] sw_data;
  logic       push, pop, err;
  logic [3:0] data_in;

  int n_tests = 0;
  int n_fail  = 0;

  stack_btn_ctrl #(.DEBOUNCE_CYCLES(4), .ERR_HOLD_CYCLES(8)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .btn_push (btn_push),
    .btn_pop  (btn_pop),
    .sw_data  (sw_data),
    .full     (full),
    .empty    (empty),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Output monitor: sampled on the falling edge, indices count falling edges.
  int         cyc = 0;
  int         n_push = 0, n_pop = 0, n_err = 0;
  int         push_at = -1, pop_at = -1, err_rise = -1, err_last = -1;
  logic [3:0] push_data = '0;
  logic       err_q = 1'b0;

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    err_q <= err;
    if (push) begin
      n_push    <= n_push + 1;
      push_at   <= cyc + 1;
      push_data <= data_in;
    end
    if (pop) begin
      n_pop  <= n_pop + 1;
      pop_at <= cyc + 1;
    end
    if (err) begin
      n_err    <= n_err + 1;
      err_last <= cyc + 1;
      if (!err_q) err_rise <= cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles; returns just after the falling edge (monitor updated).
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int c0, r, bp, bq, be, er0, el0;
    rstN = 1'b0; btn_push = 1'b0; btn_pop = 1'b0;
    sw_data = 4'h0; full = 1'b0; empty = 1'b0;
    step(2);
    chk("rst_push", push, 0);
    chk("rst_pop", pop, 0);
    chk("rst_data", data_in, 0);
    chk("rst_err", err, 0);
    rstN = 1'b1;
    step(3);

    // 1: clean press, data hold, silent release
    sw_data = 4'hA; btn_push = 1'b1;
    c0 = cyc; bp = n_push; bq = n_pop;
    step(20);
    chk("s1_push_n", n_push - bp, 1);
    chk("s1_push_at", push_at - c0, 7);
    chk("s1_push_data", push_data, 4'hA);
    chk("s1_pop_n", n_pop - bq, 0);
    sw_data = 4'h3;
    step(3);
    chk("s1_data_hold", data_in, 4'hA);
    btn_push = 1'b0; bp = n_push;
    step(20);
    chk("s1_release", n_push - bp, 0);

    // 2: bouncing pop, then steady
    bq = n_pop;
    for (int i = 0; i < 3; i++) begin
      btn_pop = 1'b1; step(2);
      btn_pop = 1'b0; step(2);
    end
    chk("s2_bounce", n_pop - bq, 0);
    btn_pop = 1'b1; c0 = cyc;
    step(15);
    chk("s2_pop_n", n_pop - bq, 1);
    chk("s2_pop_at", pop_at - c0, 7);
    chk("s2_data_hold", data_in, 4'hA);
    btn_pop = 1'b0;
    step(20);

    // 3: simultaneous press with empty=1
    empty = 1'b1; sw_data = 4'h5;
    bp = n_push; bq = n_pop; be = n_err;
    btn_push = 1'b1; btn_pop = 1'b1; c0 = cyc;
    step(15);
    chk("s3_push_n", n_push - bp, 1);
    chk("s3_pop_n", n_pop - bq, 1);
    chk("s3_push_at", push_at - c0, 7);
    chk("s3_pop_at", pop_at - c0, 7);
    chk("s3_data", push_data, 4'h5);
    btn_push = 1'b0; btn_pop = 1'b0;
    step(20);
    chk("s3_err_n", n_err - be, 0);

    // 4: illegal pop on empty, retriggered by illegal push on full
    sw_data = 4'h3; empty = 1'b1; full = 1'b0;
    bp = n_push; bq = n_pop; be = n_err; er0 = err_rise; el0 = err_last;
    btn_pop = 1'b1; c0 = cyc;
    step(5);
    full = 1'b1; btn_push = 1'b1;
    step(25);
    chk("s4_pop_n", n_pop - bq, 1);
    chk("s4_pop_at", pop_at - c0, 7);
    chk("s4_push_n", n_push - bp, 1);
    chk("s4_push_at", push_at - c0, 12);
    chk("s4_err_n", n_err - be, ERR_ON ? 13 : 0);
    chk("s4_err_rise", err_rise, ERR_ON ? c0 + 8 : er0);
    chk("s4_err_last", err_last, ERR_ON ? c0 + 20 : el0);
    chk("s4_err_now", err, 0);
    chk("s4_data", data_in, 4'h3);
    btn_push = 1'b0; btn_pop = 1'b0; full = 1'b0; empty = 1'b0;
    step(20);

    // 5: reset during debounce, button held through release
    sw_data = 4'h6; btn_push = 1'b1; c0 = cyc; bp = n_push;
    step(4);
    rstN = 1'b0;
    #1;
    chk("s5_rst_push", push, 0);
    chk("s5_rst_pop", pop, 0);
    chk("s5_rst_data", data_in, 0);
    chk("s5_rst_err", err, 0);
    step(1);
    rstN = 1'b1; r = cyc;
    step(20);
    chk("s5_push_n", n_push - bp, 1);
    chk("s5_push_at", push_at - r, 7);
    chk("s5_data", push_data, 4'h6);
    btn_push = 1'b0;
    step(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_btn_ctrl.md
# stack_btn_ctrl

Front-end stage directly upstream of the 8x4 stack on the lab board. Turns two raw, bouncing push-buttons and four data switches into clean single-cycle `push`/`pop` strobes and a registered 4-bit `data_in` for the stack. It also raises an error indicator when the user requests an operation the stack cannot perform, using the stack's `full`/`empty` flags.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a button level is accepted. Legal range 2..2^20. The board build overrides it to 1_000_000.
- `ERR_HOLD_CYCLES`, default 8: cycles `err` stays high after an illegal request. Must be at least 1.

Ports:
- `clk`  in  1: system clock. All state updates on the rising edge.
- `rstN`  in  1: reset, asynchronous, active-low.
- `btn_push`  in  1: raw push button, asynchronous, active-high.
- `btn_pop`  in  1: raw pop button, asynchronous, active-high.
- `sw_data`  in  4: raw data switches, asynchronous.
- `full`  in  1: stack full flag.
- `empty`  in  1: stack empty flag.
- `push`  out  1: one-cycle push strobe to the stack.
- `pop`  out  1: one-cycle pop strobe to the stack.
- `data_in`  out  4: registered data for the stack.
- `err`  out  1: illegal-request indicator, drives an LED.

## Operation
- **Synchronizers:** each of `btn_push`, `btn_pop` and `sw_data[3:0]` passes through a 2-flop synchronizer. The second-stage outputs are called `s_push`, `s_pop`, `s_data`.
- **Debounce** (independent per button): holds a `stable` level and a counter `cnt`, width ceil(log2(DEBOUNCE_CYCLES)).
  - If `s == stable`, `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= s` and `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `stable`.
- **Strobes:**
  - `push <= stable_push & ~stable_push_d`, where `_d` is `stable` delayed one cycle. `pop` is generated the same way.
  - Each strobe is high for exactly one cycle per accepted press. Release edges produce nothing. Holding a button produces no repeats.
- **Simultaneous:** when both strobes rise in the same cycle, both are asserted together. The stack resolves combined push+pop itself.
- **Data:**
  - `data_in <= s_data` on every cycle in which `push` is being asserted (same edge).
  - Otherwise `data_in` holds, so it stays stable for the stack's sampling edge and afterwards.
- **Error detection:** in the cycle a strobe is being asserted, the request is illegal when either holds:
  - push without pop while `full == 1`;
  - pop without push while `empty == 1`.
  
  Push+pop together is never illegal. The strobes are still issued, because the stack ignores invalid operations.

## Timing
- **Reset:** while `rstN` is low, `push=0`, `pop=0`, `data_in=0`, `err=0`. All synchronizer flops, `stable`, `_d`, `cnt` and the error counter are 0. Reset takes effect immediately (asynchronous); release is observed at the next rising edge.
- **Latency:** let the raw button rise be sampled at edge 0.
  - `s` is high after edge 1.
  - `stable` rises after edge 1+DEBOUNCE_CYCLES.
  - `push` is high during the cycle following edge 2+DEBOUNCE_CYCLES, for one cycle.
- **Error state machine:** two states, IDLE and HOLD.
  - IDLE -> HOLD on an illegal request: load the counter with ERR_HOLD_CYCLES and set `err=1` from the next edge.
  - In HOLD the counter decrements each cycle; on reaching 1, go to IDLE and clear `err`.
  - A new illegal request in HOLD reloads the counter (retrigger).
  - `err` is high for exactly ERR_HOLD_CYCLES cycles after the last illegal request.
- **Flag sampling:** `full`/`empty` are sampled in the strobe cycle, i.e. before the stack updates on that edge.
- **Reset mid-operation:** a press that is partially debounced is discarded. After reset the button must be seen high for a full debounce window. A button held through reset release produces one strobe after DEBOUNCE_CYCLES+3 cycles.

## Configuration
- Macro `STACK_BTN_ERR_EN`.
  - **Defined:** error detection and the IDLE/HOLD logic are built as described.
  - **Undefined:** `err` is tied to 0 and no error counter exists. `full`/`empty` are left unused. `push`/`pop`/`data_in` behaviour is identical in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and ERR_HOLD_CYCLES=8.

1. **Clean press:** raise `btn_push` with `sw_data=4'hA` and hold for 20 cycles -> exactly one `push` pulse, in the 7th cycle after the sampling edge; `data_in=4'hA` from that cycle on; no pulse on release.
2. **Bounce:** toggle `btn_pop` high/low every 2 cycles for 12 cycles, then hold high -> no `pop` during the bouncing; exactly one `pop` 7 cycles into the steady-high period.
3. **Simultaneous:** raise both buttons at the same edge -> `push` and `pop` high in the same single cycle; `err` stays 0 even with `empty=1`.
4. **Illegal:**
   - With `empty=1`, press pop -> `pop` pulses and `err` is high for 8 cycles.
   - A second illegal press while `err` is still high -> `err` is extended to 8 cycles after the second request.
   - With `full=1`, press push -> `err` is asserted.
5. **Reset mid-debounce:** assert `rstN=0` 2 cycles after `s_push` rises, release 1 cycle later while the button is held -> all outputs go to 0 immediately; exactly one `push` appears DEBOUNCE_CYCLES+3 cycles after reset release.
6. **Macro off:** rebuild without `STACK_BTN_ERR_EN` and rerun scenario 4 -> `err` stays 0 throughout; strobe timing is unchanged.
